// File: rtl/prog_sequencer_if.sv
// Sequencer-side bus: synchronous instruction ROM port plus run/done handshake to the control FSM.
// The ROM word is at least 10 bits wide so the full instruction fits even with a 9-bit data path.
interface prog_sequencer_if #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned ADDR_W = 6
);
  localparam int unsigned IMEM_W = (DATA_W > 10) ? DATA_W : 10;

  logic [ADDR_W-1:0] imem_addr;
  logic [IMEM_W-1:0] imem_rdata;
  logic              core_run;
  logic [3:0]        core_func;
  logic [2:0]        core_rx;
  logic [2:0]        core_ry;
  logic [DATA_W-1:0] core_din;
  logic              core_done;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output core_run,
    output core_func,
    output core_rx,
    output core_ry,
    output core_din,
    input  core_done
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  core_run,
    input  core_func,
    input  core_rx,
    input  core_ry,
    input  core_din,
    output core_done
  );
endinterface

// File: rtl/prog_sequencer.sv
// Program sequencer: fetches instructions and LOAD immediates from a synchronous ROM, owns PC,
// JMP and HALT, and issues each remaining instruction to the control FSM via run/done.
module prog_sequencer #(
  parameter int unsigned DATA_W     = 9,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned START_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_halt_req,
  prog_sequencer_if.master  io_bus,
  output logic              o_busy,
  output logic              o_halted,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_pc
);

  localparam logic [ADDR_W-1:0] StartPc = ADDR_W'(START_ADDR);
  localparam logic [3:0]        OpHalt  = 4'h0;
  localparam logic [3:0]        OpLoad  = 4'h1;
  localparam logic [3:0]        OpJmp   = 4'hf;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StWait,
    StDecode,
    StImmFetch,
    StImmWait,
    StImmCap,
    StIssue,
    StWaitDone,
    StHalted
  } state_e;

  state_e              r_state;
  logic [9:0]          r_ir;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic                r_core_run;
  logic [3:0]          r_core_func;
  logic [2:0]          r_core_rx;
  logic [2:0]          r_core_ry;
  logic [DATA_W-1:0]   r_core_din;
  logic                r_busy;
  logic                r_halted;
  logic                r_err;

  logic [9:0]          w_instr;
  logic [3:0]          w_func;
  logic                w_legal;
  logic [ADDR_W-1:0]   w_jmp_pc;
  logic [DATA_W-1:0]   w_imm;
  logic [ADDR_W-1:0]   w_pc_step;

  assign w_instr   = io_bus.imem_rdata[9:0];
  assign w_func    = w_instr[9:6];
  assign w_legal   = (w_func <= 4'h7) || (w_func == OpJmp);
  assign w_jmp_pc  = ADDR_W'({w_instr[5:3], w_instr[2:0]});
  assign w_imm     = io_bus.imem_rdata[DATA_W-1:0];
  // A LOAD consumes its immediate word as well, so it advances the PC by two.
  assign w_pc_step = (r_core_func == OpLoad) ? ADDR_W'(2) : ADDR_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_ir        <= '0;
      r_pc        <= StartPc;
      r_imem_addr <= StartPc;
      r_core_run  <= 1'b0;
      r_core_func <= '0;
      r_core_rx   <= '0;
      r_core_ry   <= '0;
      r_core_din  <= '0;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_core_run <= 1'b0;
      unique case (r_state)
        StIdle, StHalted: begin
          if (i_start) begin
            r_state  <= StFetch;
            r_pc     <= StartPc;
            r_err    <= 1'b0;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
          end
        end
        StFetch: begin
          if (i_halt_req) begin
            r_state  <= StHalted;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else begin
            r_imem_addr <= r_pc;
            r_state     <= StWait;
          end
        end
        StWait: begin
          r_state <= StDecode;
        end
        StDecode: begin
          r_ir <= w_instr;
          if ((w_func == OpHalt) || !w_legal) begin
            r_state  <= StHalted;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
            r_err    <= !w_legal;
          end else if (w_func == OpJmp) begin
            r_pc    <= w_jmp_pc;
            r_state <= StFetch;
          end else if (w_func == OpLoad) begin
            r_state <= StImmFetch;
          end else begin
            r_core_run  <= 1'b1;
            r_core_func <= w_func;
            r_core_rx   <= w_instr[5:3];
            r_core_ry   <= w_instr[2:0];
            r_state     <= StIssue;
          end
        end
        StImmFetch: begin
          r_imem_addr <= r_pc + ADDR_W'(1);
          r_state     <= StImmWait;
        end
        StImmWait: begin
          r_state <= StImmCap;
        end
        StImmCap: begin
          r_core_din  <= w_imm;
          r_core_run  <= 1'b1;
          r_core_func <= r_ir[9:6];
          r_core_rx   <= r_ir[5:3];
          r_core_ry   <= r_ir[2:0];
          r_state     <= StIssue;
        end
        StIssue: begin
          // core_done is deliberately not looked at here.
          r_state <= StWaitDone;
        end
        StWaitDone: begin
          if (io_bus.core_done) begin
            r_pc       <= r_pc + w_pc_step;
            r_core_din <= '0;
            r_state    <= StFetch;
          end
        end
        default: begin
          r_state  <= StIdle;
          r_busy   <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.imem_addr = r_imem_addr;
  assign io_bus.core_run  = r_core_run;
  assign io_bus.core_func = r_core_func;
  assign io_bus.core_rx   = r_core_rx;
  assign io_bus.core_ry   = r_core_ry;
  assign io_bus.core_din  = r_core_din;
  assign o_busy           = r_busy;
  assign o_halted         = r_halted;
  assign o_err            = r_err;
  assign o_pc             = r_pc;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: an instruction-level timeline model predicts every core_run and
// busy/halted/err per cycle; directed programs add literal expectations.
module tb_prog_sequencer;
  localparam int unsigned DATA_W = 9;
  localparam int unsigned ADDR_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic halt_req = 1'b0;
  logic busy, halted, err;
  logic [ADDR_W-1:0] pc;

  prog_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  prog_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .START_ADDR(0)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_halt_req (halt_req),
    .io_bus     (bus),
    .o_busy     (busy),
    .o_halted   (halted),
    .o_err      (err),
    .o_pc       (pc)
  );

  always #5 clk = ~clk;

  logic [9:0] rom [64];
  always @(posedge clk) bus.imem_rdata <= rom[bus.imem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] func;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [8:0] din;
    logic [5:0] pc;
  } run_t;

  run_t exp_q[$];
  run_t log_q[$];
  int   lat [512];
  bit   spur;
  bit   chk_en;
  int   m_first, m_halt, m_err, m_pc;
  int   n_chk, n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [9:0] ins(input int f, input int x, input int y);
    logic [3:0] fv;
    logic [2:0] xv, yv;
    fv = f[3:0];
    xv = x[2:0];
    yv = y[2:0];
    return {fv, xv, yv};
  endfunction

  // Walk the program instruction by instruction, timing each step in whole cycles.
  function automatic void build_model(input int s, input int h);
    int f, p, n;
    logic [9:0] w, wi;
    logic [3:0] fn;
    run_t e;
    f = s + 1; p = 0; n = 0;
    m_first = s + 1; m_halt = -1; m_err = -1; m_pc = 0;
    exp_q.delete();
    for (int it = 0; it < 4000; it++) begin
      if (f >= h) begin
        m_halt = f + 1; m_pc = p;
        return;
      end
      w  = rom[p];
      fn = w[9:6];
      if (fn == 4'h0 || (fn > 4'h7 && fn != 4'hf)) begin
        m_halt = f + 3; m_pc = p;
        if (fn != 4'h0) m_err = f + 3;
        return;
      end
      if (fn == 4'hf) begin
        p = int'(w[5:0]);
        f = f + 3;
      end else begin
        e.func = fn; e.rx = w[5:3]; e.ry = w[2:0]; e.pc = 6'(p);
        if (fn == 4'h1) begin
          wi = rom[(p + 1) % 64];
          e.cyc = f + 6; e.din = wi[8:0];
        end else begin
          e.cyc = f + 3; e.din = 9'h0;
        end
        exp_q.push_back(e);
        f = e.cyc + lat[n % 512] + 1;
        n++;
        p = (p + ((fn == 4'h1) ? 2 : 1)) % 64;
      end
    end
  endfunction

  task automatic at_cyc(input int k);
    do @(negedge clk); while (cyc < k);
    #1;
  endtask

  // Core responder: done arrives lat[n] cycles after the n-th run, optional extra in ISSUE.
  initial begin
    int due, idx;
    due = -1; idx = 0;
    bus.core_done = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      bus.core_done = 1'b0;
      if (!busy) idx = 0;
      if (bus.core_run) begin
        due = cyc + lat[idx % 512];
        idx++;
        if (spur) bus.core_done = 1'b1;
      end
      if (cyc == due) bus.core_done = 1'b1;
    end
  end

  // Per-cycle comparison against the timeline model.
  initial begin
    run_t e;
    bit   er;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        er = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        check("core_run", bus.core_run, er);
        if (bus.core_run) begin
          e.cyc = cyc; e.func = bus.core_func; e.rx = bus.core_rx; e.ry = bus.core_ry;
          e.din = bus.core_din; e.pc = pc;
          log_q.push_back(e);
        end
        if (er) begin
          e = exp_q.pop_front();
          check("core_func", bus.core_func, e.func);
          check("core_rx", bus.core_rx, e.rx);
          check("core_ry", bus.core_ry, e.ry);
          check("core_din", bus.core_din, e.din);
          check("pc_at_run", pc, e.pc);
        end
        check("busy", busy, (cyc >= m_first) && (cyc < m_halt));
        check("halted", halted, cyc >= m_halt);
        check("err", err, (m_err >= 0) && (cyc >= m_err));
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_run"}, bus.core_run, 0);
    check({tag, "_func"}, bus.core_func, 0);
    check({tag, "_rxry"}, {bus.core_rx, bus.core_ry}, 0);
    check({tag, "_din"}, bus.core_din, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_pc"}, pc, 0);
    check({tag, "_imem_addr"}, bus.imem_addr, 0);
  endtask

  // Start a program from IDLE/HALTED; halt_req goes high h_off cycles after the start cycle.
  task automatic run_prog(input int h_off, input int busy_start);
    int s, h, stop;
    s = cyc;
    h = s + h_off;
    log_q.delete();
    build_model(s, h);
    check("model_halts", (m_halt > 0), 1);
    stop = (m_halt > 0) ? m_halt + 3 : s + 20;
    start = 1'b1;
    chk_en = 1'b1;
    for (int c = s + 1; c <= stop; c++) begin
      at_cyc(c);
      start    = (busy_start > 0) && (c == s + busy_start);
      halt_req = (c >= h);
    end
    chk_en = 1'b0; start = 1'b0; halt_req = 1'b0;
    check("runs_left", exp_q.size(), 0);
    check("final_pc", pc, m_pc);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 10'h0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s, r;
    logic [3:0] opt [16];
    opt = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h1,
            4'h3, 4'h2, 4'hf, 4'hf, 4'h0, 4'h8, 4'hb, 4'h1};
    n_chk = 0; n_pass = 0; chk_en = 1'b0; spur = 1'b0;
    for (int i = 0; i < 512; i++) lat[i] = 2;
    clear_rom();
    rst = 1'b1;
    at_cyc(1);
    at_cyc(2);
    rst = 1'b0;
    at_cyc(3);
    check_reset_vals("por");

    // Two LOADs then ADD then HALT.
    clear_rom();
    rom[0] = ins(1, 1, 0); rom[1] = 10'h00A;
    rom[2] = ins(1, 2, 0); rom[3] = 10'h005;
    rom[4] = ins(3, 1, 2); rom[5] = ins(0, 0, 0);
    s = cyc;
    run_prog(1000, 0);
    check("t2_model_halt_lat", m_halt - s, 28);
    check("t2_nruns", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("t2_run0", {log_q[0].func, log_q[0].rx, log_q[0].ry, log_q[0].din}, {4'h1, 3'd1, 3'd0, 9'h00A});
      check("t2_run1", {log_q[1].func, log_q[1].rx, log_q[1].ry, log_q[1].din}, {4'h1, 3'd2, 3'd0, 9'h005});
      check("t2_run2", {log_q[2].func, log_q[2].rx, log_q[2].ry, log_q[2].din}, {4'h3, 3'd1, 3'd2, 9'h000});
      check("t2_run_gap", log_q[1].cyc - log_q[0].cyc, 9);
    end
    check("t2_halted", halted, 1);
    check("t2_pc", pc, 5);

    // ADD / JMP 0 loop; halt_req rises after the third ADD, while the JMP is in its ROM cycle.
    clear_rom();
    rom[0] = ins(3, 4, 5); rom[1] = ins(15, 0, 0);
    run_prog(26, 0);
    check("t3_nruns", log_q.size(), 3);
    check("t3_halted", halted, 1);
    check("t3_pc", pc, 0);
    check("t3_err", err, 0);

    // Illegal opcode, then restart from HALTED.
    clear_rom();
    rom[0] = ins(8, 0, 0);
    run_prog(1000, 0);
    check("t4_nruns", log_q.size(), 0);
    check("t4_err", err, 1);
    check("t4_halted", halted, 1);
    run_prog(1000, 0);
    check("t4b_nruns", log_q.size(), 0);

    // Reset from HALTED with err set.
    rst = 1'b1;
    at_cyc(cyc + 1);
    at_cyc(cyc + 1);
    rst = 1'b0;
    at_cyc(cyc + 1);
    check_reset_vals("t1");

    // Reset while waiting for done; the late done must not restart anything.
    clear_rom();
    rom[0] = ins(15, 0, 5); rom[5] = ins(2, 3, 6);
    lat[0] = 4;
    s = cyc;
    build_model(s, s + 100000);
    r = (exp_q.size() > 0) ? exp_q[0].cyc : s + 7;
    check("t6_model_run", r - s, 7);
    log_q.delete();
    start = 1'b1; chk_en = 1'b1;
    for (int c = s + 1; c <= r + 1; c++) begin
      at_cyc(c);
      start = 1'b0;
    end
    chk_en = 1'b0;
    rst = 1'b1;
    at_cyc(r + 2);
    at_cyc(r + 3);
    rst = 1'b0;
    for (int c = r + 3; c <= r + 9; c++) begin
      at_cyc(c);
      check("t6_no_run", bus.core_run, 0);
      check("t6_idle", {busy, halted}, 0);
    end
    check_reset_vals("t6");
    check("t6_nruns", log_q.size(), 1);
    exp_q.delete();
    lat[0] = 2;

    // LOAD at 63 with immediate from address 0; spurious done in ISSUE; start while busy.
    clear_rom();
    rom[0] = ins(15, 7, 7); rom[63] = ins(1, 3, 0); rom[1] = ins(0, 0, 0);
    spur = 1'b1;
    lat[0] = 1;
    run_prog(1000, 2);
    check("t5_nruns", log_q.size(), 1);
    if (log_q.size() == 1) begin
      check("t5_din", log_q[0].din, 9'h1FF);
      check("t5_run_pc", log_q[0].pc, 63);
    end
    check("t5_pc", pc, 1);
    check("t5_halted", halted, 1);

    // Random programs.
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 64; i++) rom[i] = {opt[$urandom % 16], 6'($urandom)};
      for (int i = 0; i < 512; i++) lat[i] = int'($urandom_range(1, 4));
      spur = 1'($urandom);
      run_prog(int'($urandom_range(5, 300)), ($urandom % 2 == 0) ? 2 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
